// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch target buffer and its update path.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_index;
    typedef logic [11:0] lc3b_btb_tag;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word target;
        logic     taken;
    } btb_upd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } btb_upd_state_e;

    function automatic logic [1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue between branch resolution and the BTB write port.
// Head entry is visible combinationally so the controller can index the arrays.
module btb_upd_fifo
    import lc3b_types::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  btb_upd_t      din,
    input  logic          pop,
    output btb_upd_t      head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    btb_upd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Power-of-two depth, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Queues resolved branches and applies them to a 2-way BTB via READ/WRITE passes.
// Build option BTB_INVALIDATE_EN: a not-taken hit clears the hit way instead of only touching LRU.
module btb_update_ctrl
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  lc3b_word    upd_pc,
    input  lc3b_word    upd_target,
    input  logic        upd_taken,
    output lc3b_index   btb_index,
    input  lc3b_btb_tag tag0,
    input  lc3b_btb_tag tag1,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        lru_in,
    output logic        lru_write,
    output logic        lru_out,
    output logic [1:0]  way_write,
    output lc3b_btb_tag tag_out,
    output lc3b_word    target_out,
    output logic        valid_out,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    btb_upd_state_e state_q, state_d;
    btb_upd_t       head;
    btb_upd_t       din;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    lc3b_btb_tag    tag0_q, tag1_q;
    logic [1:0]     valid_q;
    logic           lru_q;

    lc3b_index      head_index;
    lc3b_btb_tag    head_tag;
    logic           pc_lsb_unused;
    logic [1:0]     hit_vec;
    logic           hit;
    logic           hit_way;
    logic           victim_way;

    // rst gates ready directly so nothing is accepted while reset is held.
    assign upd_ready = !rst && !fifo_full;
    assign push      = upd_valid && upd_ready;
    assign pop       = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign din       = '{pc: upd_pc, target: upd_target, taken: upd_taken};

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_index    = head.pc[3:1];
    assign head_tag      = head.pc[15:4];
    assign pc_lsb_unused = head.pc[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Array read data is only trustworthy at the end of READ; hold it for WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag0_q  <= '0;
            tag1_q  <= '0;
            valid_q <= '0;
            lru_q   <= 1'b0;
        end else if (state_q == ST_READ) begin
            tag0_q  <= tag0;
            tag1_q  <= tag1;
            valid_q <= {valid1, valid0};
            lru_q   <= lru_in;
        end
    end

    // Going straight back to READ when more work is queued keeps two cycles per update.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ((fifo_count > CW'(1)) || push) ? ST_READ : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign hit_vec    = {valid_q[1] && (tag1_q == head_tag), valid_q[0] && (tag0_q == head_tag)};
    assign hit        = |hit_vec;
    assign hit_way    = !hit_vec[0];
    assign victim_way = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);

    always_comb begin
        way_write  = '0;
        lru_write  = 1'b0;
        lru_out    = 1'b0;
        tag_out    = '0;
        target_out = '0;
        valid_out  = 1'b0;
        btb_index  = (state_q == ST_IDLE) ? '0 : head_index;
        if (state_q == ST_WRITE) begin
            if (hit) begin
                if (head.taken) begin
                    way_write  = way_onehot(hit_way);
                    tag_out    = head_tag;
                    target_out = head.target;
                    valid_out  = 1'b1;
                    lru_write  = 1'b1;
                    lru_out    = ~hit_way;
                end else begin
`ifdef BTB_INVALIDATE_EN
                    way_write  = way_onehot(hit_way);
                    tag_out    = head_tag;
                    target_out = head.target;
                    valid_out  = 1'b0;
                    lru_write  = 1'b1;
                    lru_out    = hit_way;
`else
                    lru_write  = 1'b1;
                    lru_out    = ~hit_way;
`endif
                end
            end else if (head.taken) begin
                way_write  = way_onehot(victim_way);
                tag_out    = head_tag;
                target_out = head.target;
                valid_out  = 1'b1;
                lru_write  = 1'b1;
                lru_out    = ~victim_way;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed corner cases plus random traffic vs. a BTB reference model.
module tb_btb_update_ctrl;
    import lc3b_types::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    lc3b_word    upd_pc = '0;
    lc3b_word    upd_target = '0;
    logic        upd_taken = 1'b0;
    lc3b_index   btb_index;
    lc3b_btb_tag tag0, tag1;
    logic        valid0, valid1, lru_in;
    logic        lru_write, lru_out;
    logic [1:0]  way_write;
    lc3b_btb_tag tag_out;
    lc3b_word    target_out;
    logic        valid_out;
    logic        busy;

    btb_update_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .btb_index  (btb_index),
        .tag0       (tag0),
        .tag1       (tag1),
        .valid0     (valid0),
        .valid1     (valid1),
        .lru_in     (lru_in),
        .lru_write  (lru_write),
        .lru_out    (lru_out),
        .way_write  (way_write),
        .tag_out    (tag_out),
        .target_out (target_out),
        .valid_out  (valid_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // BTB storage seen by the DUT (written on the falling edge, like the real arrays)
    bit [11:0] e_tag [8][2];
    bit [15:0] e_tgt [8][2];
    bit        e_val [8][2];
    bit        e_lru [8];

    // Reference model state
    bit [11:0] m_tag [8][2];
    bit [15:0] m_tgt [8][2];
    bit        m_val [8][2];
    bit        m_lru [8];

    assign tag0   = e_tag[btb_index][0];
    assign tag1   = e_tag[btb_index][1];
    assign valid0 = e_val[btb_index][0];
    assign valid1 = e_val[btb_index][1];
    assign lru_in = e_lru[btb_index];

    typedef struct {
        bit [1:0]  ww;
        bit [11:0] tg;
        bit [15:0] tgt;
        bit        v;
        bit        lw;
        bit        lru;
        bit [2:0]  idx;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = -1;
    int accept_cyc  = 0;
    bit spacing_on  = 0;
    bit saw_full    = 0;
    bit [1:0]  last_ww;
    bit [11:0] last_tag;
    bit [15:0] last_tgt;
    bit        last_v, last_lw, last_lru;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (upd_valid && !upd_ready && !rst) saw_full = 1'b1;
        if (way_write != 2'b00 || lru_write) begin
            wr_cnt++;
            if (spacing_on && prev_wr_cyc >= 0) check("spacing", cyc - prev_wr_cyc, 2);
            prev_wr_cyc = cyc;
            last_wr_cyc = cyc;
            last_ww  = way_write;
            last_tag = tag_out;
            last_tgt = target_out;
            last_v   = valid_out;
            last_lw  = lru_write;
            last_lru = lru_out;
            $display("write cyc=%0d idx=%0d ww=%b tag=%h tgt=%h v=%b lw=%b lru=%b",
                     cyc, btb_index, way_write, tag_out, target_out, valid_out, lru_write, lru_out);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("way_write", way_write, e.ww);
                check("lru_write", lru_write, e.lw);
                check("lru_out", lru_out, e.lru);
                check("btb_index", btb_index, e.idx);
                if (e.ww != 2'b00) begin
                    check("tag_out", tag_out, e.tg);
                    check("target_out", target_out, e.tgt);
                    check("valid_out", valid_out, e.v);
                end
            end
            for (int w = 0; w < 2; w++) begin
                if (way_write[w]) begin
                    e_tag[btb_index][w] = tag_out;
                    e_tgt[btb_index][w] = target_out;
                    e_val[btb_index][w] = valid_out;
                end
            end
            if (lru_write) e_lru[btb_index] = lru_out;
        end
    end

    // Apply one update to the model in acceptance order and queue any expected write.
    task automatic model_apply(input bit [15:0] pc, input bit [15:0] tgt, input bit tk);
        exp_t e;
        int   hit_w = -1;
        int   vic;
        bit [2:0]  idx = pc[3:1];
        bit [11:0] tg  = pc[15:4];
        e = '{ww: 2'b00, tg: tg, tgt: tgt, v: 1'b0, lw: 1'b0, lru: 1'b0, idx: idx};
        for (int w = 0; w < 2; w++)
            if (hit_w < 0 && m_val[idx][w] && m_tag[idx][w] == tg) hit_w = w;
        if (hit_w >= 0) begin
            e.lw = 1'b1;
            if (tk) begin
                e.ww = 2'(1 << hit_w);
                e.v = 1'b1;
                e.lru = (hit_w == 0);
                m_tgt[idx][hit_w] = tgt;
            end else begin
`ifdef BTB_INVALIDATE_EN
                e.ww = 2'(1 << hit_w);
                e.v = 1'b0;
                e.lru = (hit_w == 1);
                m_val[idx][hit_w] = 1'b0;
`else
                e.lru = (hit_w == 0);
`endif
            end
            m_lru[idx] = e.lru;
            exp_q.push_back(e);
        end else if (tk) begin
            if (!m_val[idx][0]) vic = 0;
            else if (!m_val[idx][1]) vic = 1;
            else vic = m_lru[idx] ? 1 : 0;
            e.ww = 2'(1 << vic);
            e.v = 1'b1;
            e.lw = 1'b1;
            e.lru = (vic == 0);
            m_tag[idx][vic] = tg;
            m_tgt[idx][vic] = tgt;
            m_val[idx][vic] = 1'b1;
            m_lru[idx] = e.lru;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_arrays();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                e_tag[s][w] = '0; e_tgt[s][w] = '0; e_val[s][w] = 1'b0;
                m_tag[s][w] = '0; m_tgt[s][w] = '0; m_val[s][w] = 1'b0;
            end
            e_lru[s] = 1'b0;
            m_lru[s] = 1'b0;
        end
    endtask

    task automatic preset(input int s, input int w, input bit [11:0] tg, input bit v);
        e_tag[s][w] = tg; e_val[s][w] = v; e_tgt[s][w] = 16'h0;
        m_tag[s][w] = tg; m_val[s][w] = v; m_tgt[s][w] = 16'h0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit [15:0] pc, input bit [15:0] tgt, input bit tk);
        int guard = 0;
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        forever begin
            @(negedge clk);
            if (upd_ready) break;
            guard++;
            if (guard > 200) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        model_apply(pc, tgt, tk);
        @(posedge clk);
        accept_cyc = cyc + 1;
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int guard = 0;
        while (wr_cnt < n && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("write_seen", (wr_cnt >= n), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit [11:0] pool [3];
        pool[0] = 12'h010; pool[1] = 12'h020; pool[2] = 12'h030;
        clear_arrays();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", upd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_way_write", way_write, 0);
        check("rst_lru_write", lru_write, 0);
        check("rst_index", btb_index, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty set, taken: fills way0 two cycles after enqueue
        n0 = wr_cnt;
        send(16'h300A, 16'h3100, 1'b1);
        wait_writes(n0 + 1);
        check("t1_latency", last_wr_cyc - accept_cyc, 2);
        check("t1_ww", last_ww, 2'b01);
        check("t1_tag", last_tag, 12'h300);
        check("t1_tgt", last_tgt, 16'h3100);
        check("t1_lru", last_lru, 1);
        drain();

        // Both valid, no match, lru=1: evict way1
        preset(2, 0, 12'h111, 1'b1);
        preset(2, 1, 12'h222, 1'b1);
        e_lru[2] = 1'b1; m_lru[2] = 1'b1;
        n0 = wr_cnt;
        send(16'h5004, 16'h5100, 1'b1);
        wait_writes(n0 + 1);
        check("t2_ww", last_ww, 2'b10);
        check("t2_lru", last_lru, 0);
        drain();

        // Hit way1, not taken
        preset(3, 0, 12'hAAA, 1'b1);
        preset(3, 1, 12'hBBB, 1'b1);
        n0 = wr_cnt;
        send(16'hBBB6, 16'h1234, 1'b0);
        wait_writes(n0 + 1);
`ifdef BTB_INVALIDATE_EN
        check("t3_ww", last_ww, 2'b10);
        check("t3_valid", last_v, 0);
        check("t3_lru", last_lru, 1);
`else
        check("t3_ww", last_ww, 2'b00);
        check("t3_lw", last_lw, 1);
        check("t3_lru", last_lru, 0);
`endif
        drain();

        // Miss, not taken: consumed silently
        n0 = wr_cnt;
        send(16'h0004, 16'h0000, 1'b0);
        drain();
        check("t4_no_write", wr_cnt - n0, 0);
        check("t4_queue", exp_q.size(), 0);

        // Back-to-back burst: backpressure, order, 2-cycle spacing
        n0 = wr_cnt;
        saw_full = 1'b0;
        spacing_on = 1'b1;
        prev_wr_cyc = -1;
        for (int i = 0; i < DEPTH + 2; i++)
            send(16'($urandom), 16'($urandom), 1'b1);
        drain();
        spacing_on = 1'b0;
        check("t5_full_seen", saw_full, 1);
        check("t5_writes", wr_cnt - n0, DEPTH + 2);

        // Reset in the middle of a WRITE
        for (int i = 0; i < 3; i++)
            send({12'h0F0 + 12'(i), 3'(i), 1'b0}, 16'h7000 + 16'(i), 1'b1);
        begin
            int guard = 0;
            forever begin
                @(posedge clk); #1;
                if (way_write != 2'b00) break;
                guard++;
                if (guard > 20) begin
                    check("t6_find_write", 0, 1);
                    break;
                end
            end
        end
        rst = 1'b1;
        #1;
        check("t6_ww", way_write, 0);
        check("t6_lw", lru_write, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", upd_ready, 0);
        check("t6_index", btb_index, 0);
        exp_q.delete();
        clear_arrays();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        n0 = wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_write", wr_cnt - n0, 0);
        check("t6_busy_after", busy, 0);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            bit [15:0] pc;
            pc = {pool[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 1'b0};
            send(pc, 16'($urandom), ($urandom_range(0, 9) < 7));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        check("rand_queue_empty", exp_q.size(), 0);
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                check("final_valid", e_val[s][w], m_val[s][w]);
                if (m_val[s][w]) begin
                    check("final_tag", e_tag[s][w], m_tag[s][w]);
                    check("final_tgt", e_tgt[s][w], m_tgt[s][w]);
                end
            end
            check("final_lru", e_lru[s], m_lru[s]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
